// File: rtl/sr_drv_pkg.sv
// Shared types and limits for the SR latch driver: FSM states, counter width
// and the legal range of the pulse/gap width parameters.
package sr_drv_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned W_MIN = 1;
  localparam int unsigned W_MAX = (1 << CNT_W) - 1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PULSE,
    GAP,
    ACK
  } state_t;

  // A phase of w cycles loads w-1 and ends on the cycle the counter reads 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned w);
    return CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request handshake between the controlling logic (master) and the latch
// driver (slave).
interface sr_latch_driver_if;

  logic req_valid;
  logic req_level;
  logic req_ready;
  logic done;

  modport master (
    output req_valid,
    output req_level,
    input  req_ready,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_level,
    output req_ready,
    output done
  );

endinterface

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with a zero flag; stops at 0 rather than wrapping.
module sr_pulse_timer
  import sr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives mutually exclusive, width-controlled set/reset pulses into an SR
// latch from a valid/ready request and keeps a shadow of the latch value.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_W        = 2,
  parameter int unsigned GAP_W          = 1,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sr_latch_driver_if.slave         bus,
  output logic                     s,
  output logic                     r,
  output logic                     q_shadow
);

  if (PULSE_W < W_MIN || PULSE_W > W_MAX) begin : g_bad_pulse_w
    $error("sr_latch_driver: PULSE_W=%0d outside %0d..%0d", PULSE_W, W_MIN, W_MAX);
  end
  if (GAP_W < W_MIN || GAP_W > W_MAX) begin : g_bad_gap_w
    $error("sr_latch_driver: GAP_W=%0d outside %0d..%0d", GAP_W, W_MIN, W_MAX);
  end

  state_t           state, state_n;
  logic             s_n, r_n, qs_n;
  logic             ready, ready_n;
  logic             lvl, lvl_n;
  logic             silent, silent_n;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;
  logic             pulse_needed;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      s        <= 1'b0;
      r        <= 1'b0;
      ready    <= 1'b0;
      q_shadow <= 1'b0;
      lvl      <= 1'b0;
      silent   <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      r        <= r_n;
      ready    <= ready_n;
      q_shadow <= qs_n;
      lvl      <= lvl_n;
      silent   <= silent_n;
    end
  end

  assign pulse_needed = !SKIP_REDUNDANT || (bus.req_level != q_shadow);

  always_comb begin
    state_n  = state;
    s_n      = s;
    r_n      = r;
    ready_n  = ready;
    qs_n     = q_shadow;
    lvl_n    = lvl;
    silent_n = silent;
    load     = 1'b0;
    load_val = '0;
    case (state)
      // r still low marks the first edge after reset: start the reset pulse.
      INIT: begin
        if (!r) begin
          r_n      = 1'b1;
          load     = 1'b1;
          load_val = cnt_load(PULSE_W);
        end else if (zero) begin
          r_n      = 1'b0;
          silent_n = 1'b1;
          state_n  = GAP;
          load     = 1'b1;
          load_val = cnt_load(GAP_W);
        end
      end
      IDLE: begin
        if (bus.req_valid && ready) begin
          ready_n = 1'b0;
          if (pulse_needed) begin
            s_n      = bus.req_level;
            r_n      = ~bus.req_level;
            lvl_n    = bus.req_level;
            state_n  = PULSE;
            load     = 1'b1;
            load_val = cnt_load(PULSE_W);
          end else begin
            state_n = ACK;
          end
        end
      end
      PULSE: begin
        if (zero) begin
          s_n      = 1'b0;
          r_n      = 1'b0;
          qs_n     = lvl;
          silent_n = 1'b0;
          state_n  = GAP;
          load     = 1'b1;
          load_val = cnt_load(GAP_W);
        end
      end
      GAP: begin
        if (zero) begin
          silent_n = 1'b0;
          ready_n  = 1'b1;
          state_n  = IDLE;
        end
      end
      ACK: begin
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.done      = ((state == GAP) && zero && !silent) || (state == ACK);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized scoreboard bench for sr_latch_driver across three parameter sets,
// each driving a behavioural NOR latch whose value is compared to q_shadow.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   run = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int done_at;
    bit lvl;
    bit pulse;
  } req_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int PW = (g == 1) ? 3 : 2;
    localparam int GW = (g == 1) ? 2 : 1;
    localparam bit SK = (g == 2) ? 1'b0 : 1'b1;

    sr_latch_driver_if bus ();
    logic s, r, q_shadow;
    logic q_latch;
    int   cyc;
    req_t sb[$];

    sr_latch_driver #(
      .PULSE_W        (PW),
      .GAP_W          (GW),
      .SKIP_REDUNDANT (SK)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .s        (s),
      .r        (r),
      .q_shadow (q_shadow)
    );

    // Behavioural NOR latch; starts at 1 so the init reset pulse must clear it.
    initial q_latch = 1'b1;
    always @(s or r) begin
      if (s && !r) q_latch = 1'b1;
      else if (r && !s) q_latch = 1'b0;
    end

    always @(s or r) begin
      assert (!(s && r)) else $error("FAIL i%0d_s_and_r: s=%0d r=%0d", g, s, r);
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
    end

    // Stimulus: random valid/level each cycle; an accepted request is turned
    // into its expected outcome by a level-only model of the latch.
    initial begin : drv
      bit   shadow_m;
      req_t e;
      shadow_m      = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_level = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          shadow_m = 1'b0;
        end else if (bus.req_valid && bus.req_ready) begin
          e.t       = cyc;
          e.lvl     = bus.req_level;
          e.pulse   = !SK || (bus.req_level != shadow_m);
          e.done_at = cyc + (e.pulse ? PW + GW : 1);
          if (e.pulse) shadow_m = e.lvl;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = run && ($urandom_range(0, 3) != 0);
        bus.req_level = 1'($urandom_range(0, 1));
      end
    end

    // Checker: every cycle, derive expected outputs from the in-flight request.
    initial begin : mon
      bit   cur_shadow, has, es, er, ed, erdy, eq, el;
      int   next_ready;
      req_t h;
      cur_shadow = 1'b0;
      next_ready = PW + GW + 1;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sb.delete();
          cur_shadow = 1'b0;
          next_ready = PW + GW + 1;
          chk($sformatf("i%0d_rst_s", g), s, 0);
          chk($sformatf("i%0d_rst_r", g), r, 0);
          chk($sformatf("i%0d_rst_done", g), bus.done, 0);
          chk($sformatf("i%0d_rst_ready", g), bus.req_ready, 0);
          chk($sformatf("i%0d_rst_qshadow", g), q_shadow, 0);
          continue;
        end
        has = (sb.size() > 0) && (sb[0].t < cyc);
        if (has) h = sb[0];
        es   = has && h.pulse && h.lvl && cyc >= h.t + 1 && cyc <= h.t + PW;
        er   = (cyc >= 1 && cyc <= PW) ||
               (has && h.pulse && !h.lvl && cyc >= h.t + 1 && cyc <= h.t + PW);
        ed   = has && (cyc == h.done_at);
        erdy = !has && (cyc >= next_ready);
        eq   = (has && h.pulse && cyc >= h.t + PW + 1) ? h.lvl : cur_shadow;
        el   = (has && h.pulse) ? h.lvl : cur_shadow;
        chk($sformatf("i%0d_s", g), s, es);
        chk($sformatf("i%0d_r", g), r, er);
        chk($sformatf("i%0d_done", g), bus.done, ed);
        chk($sformatf("i%0d_ready", g), bus.req_ready, erdy);
        chk($sformatf("i%0d_qshadow", g), q_shadow, eq);
        if (cyc >= 1) chk($sformatf("i%0d_latch_q", g), q_latch, el);
        if (has && cyc >= h.done_at) begin
          if (h.pulse) cur_shadow = h.lvl;
          next_ready = cyc + 1;
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : seq
    bit found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run = 1'b1;
    repeat (400) @(posedge clk);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (g_cfg[0].s === 1'b1) found = 1'b1;
    end
    chk("mid_pulse_found", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_s", g_cfg[0].s, 0);
    chk("async_r", g_cfg[0].r, 0);
    chk("async_done", g_cfg[0].bus.done, 0);
    chk("async_qshadow", g_cfg[0].q_shadow, 0);
    chk("async_ready", g_cfg[0].bus.req_ready, 0);
    chk("async_i1_sr", {g_cfg[1].s, g_cfg[1].r}, 0);
    chk("async_i2_sr", {g_cfg[2].s, g_cfg[2].r}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (400) @(posedge clk);

    run = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous driver for a NOR-based SR latch; it is the control end of the latch's set/reset interface.
- Converts level requests on a valid/ready handshake into mutually exclusive set/reset pulses with a programmable pulse width and guard gap, so the latch never sees s=r=1.
- Keeps a shadow copy of the latch state, so the owner never has to read the latch back.
- Sits between control logic and any srlatch instance.

Parameters:
- PULSE_W, 2: cycles s or r is held high per write; legal range 1..15.
- GAP_W, 1: cycles with s=r=0 after each pulse, before the next request is accepted; legal range 1..15.
- SKIP_REDUNDANT, 1: 1 = a request equal to the shadow state produces no pulse; 0 = always pulse.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_level  input  1  desired latch value (1 = set, 0 = reset)
- req_ready  output  1  driver can accept a request (registered)
- done  output  1  one-cycle pulse when a request has completed
- s  output  1  set drive to latch (registered)
- r  output  1  reset drive to latch (registered)
- q_shadow  output  1  tracked latch value

Behaviour:
- Reset (asynchronous, rst_n=0):
  - s=0, r=0, done=0, req_ready=0, q_shadow=0.
  - state=INIT, cnt=0.
- States and transitions:
  - INIT: r=1 for PULSE_W cycles, starting the first clk edge after rst_n rises. Then GAP. No done is issued for the init sequence. q_shadow stays 0.
  - IDLE: req_ready=1. A request is accepted at edge T when req_valid && req_ready.
    - Pulse needed (level differs from q_shadow, or SKIP_REDUNDANT=0): go to PULSE. s=req_level and r=~req_level, both visible from T+1.
    - Redundant (level equals q_shadow and SKIP_REDUNDANT=1): go to ACK.
  - PULSE: s or r is held for exactly PULSE_W cycles (T+1 .. T+PULSE_W). On exit, s=r=0 and q_shadow <= latched level, both visible at T+PULSE_W+1. Then GAP.
  - GAP: s=r=0 for GAP_W cycles. done=1 in the final GAP cycle (T+PULSE_W+GAP_W), except after INIT. req_ready=1 at T+PULSE_W+GAP_W+1.
  - ACK: one cycle. done=1 at T+1, s=r=0. req_ready=1 at T+2.
- Latency, pulsed request: done at T+PULSE_W+GAP_W. Back-to-back throughput is one request per PULSE_W+GAP_W+1 cycles.
- Handshake rules:
  - req_level is sampled only at the accept edge; later changes are ignored.
  - req_valid while req_ready=0 is ignored. The request is not queued; the requester must hold it.
- Invariants:
  - s&r is never 1 in any cycle, including reset and INIT.
  - s and r are never both high at the cycle boundary between consecutive pulses; at least GAP_W zero cycles separate them.
- Counter: 4-bit cnt, loaded with W-1 on state entry, decremented to 0. No wrap: the state transitions when cnt==0.
- Reset mid-operation: s, r and done drop asynchronously. q_shadow returns to 0 and the INIT reset pulse is replayed, so the latch and the shadow re-agree.
- Illegal parameters (PULSE_W or GAP_W equal to 0, or greater than 15) are rejected by an elaboration-time check.

Decomposition:
- Package sr_drv_pkg holds:
  - the state enum: INIT, IDLE, PULSE, GAP, ACK;
  - CNT_W=4;
  - the parameter legality limits.
- One natural sub-module: sr_pulse_timer, a loadable down-counter with a zero flag, instantiated once and reused for PULSE and GAP.
- The srlatch itself stays outside. The top-level bench connects s/r to srlatch and compares q against q_shadow.

Test Plan:
- Reset release, PULSE_W=2, GAP_W=1 -> r=1 on cycles 1-2, s=r=0 on cycle 3, req_ready=1 on cycle 4, no done, q_shadow=0, latch q=0.
- Accept req_level=1 at T -> s=1 at T+1..T+2, done at T+3, q_shadow=1 at T+3, req_ready=1 at T+4; latch q=1.
- Redundant req_level=1 while q_shadow=1 and SKIP_REDUNDANT=1 -> s=r=0 throughout, done at T+1, req_ready at T+2. Same stimulus with SKIP_REDUNDANT=0 -> full 2-cycle s pulse.
- Continuous req_valid alternating 1,0,1,0, PULSE_W=3, GAP_W=2 -> accepts every 6 cycles, s/r alternate, at least 2 zero cycles between pulses, assertion s&r==0 never fires.
- req_level toggled and req_valid held during PULSE -> ignored; pulse polarity matches the level sampled at T; second request accepted only at the req_ready edge.
- rst_n pulled low mid-PULSE (s=1) -> s drops without waiting for clk, q_shadow=0, INIT r-pulse replays after release, latch q=0 matches q_shadow.
